// File: rtl/mul_seq_ctrl.sv
// Sequenced signed 32x32 -> 64-bit multiplier controller.
// The partial-product rows are accumulated ROWS_PER_CYCLE at a time into a
// 64-bit accumulator instead of being summed in one combinational tree.
// Rows 0..30 are the sign-extended multiplicand shifted by the row index and
// gated by the matching multiplier bit. Row 31 carries the negative weight
// of the multiplier sign bit, so it is subtracted.
// Valid/ready handshakes sit on both the operand side and the result side.
module mul_seq_ctrl #(
  parameter int ROWS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] p,
  output logic        busy
);

  localparam int NUM_STEPS = 32 / ROWS_PER_CYCLE;
  localparam logic [5:0] LAST_STEP = 6'(NUM_STEPS - 1);

  if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4 ||
        ROWS_PER_CYCLE == 8 || ROWS_PER_CYCLE == 16 || ROWS_PER_CYCLE == 32)) begin : g_bad_rows
    $error("mul_seq_ctrl: ROWS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [63:0] a_ext;
  logic [63:0] acc;
  logic [63:0] acc_next;
  logic [63:0] row_sum;
  logic [5:0]  step;
  logic        last_step;

  // One partial-product row; the sign-bit row has negative weight.
  function automatic logic [63:0] row_term(input logic [63:0] mcand,
                                           input logic [31:0] mult,
                                           input logic [4:0]  k);
    logic [63:0] shifted;
    shifted = mcand << k;
    if (!mult[k]) begin
      return 64'd0;
    end
    if (k == 5'd31) begin
      return -shifted;
    end
    return shifted;
  endfunction

  assign a_ext     = {{32{a_reg[31]}}, a_reg};
  assign last_step = (step == LAST_STEP);
  assign acc_next  = acc + row_sum;

  // Sum of the rows handled in the current step.
  always_comb begin
    row_sum = '0;
    for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
      row_sum = row_sum + row_term(a_ext, b_reg, 5'(int'(step) * ROWS_PER_CYCLE + j));
    end
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision from the handshakes and the step counter.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = ACCUM;
      ACCUM:   if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs follow directly from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Operand latch, accumulator, step counter and product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      step  <= '0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            step  <= '0;
          end
        end
        ACCUM: begin
          acc  <= acc_next;
          step <= step + 6'd1;
          if (last_step) begin
            p <= acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl. Four instances with different
// ROWS_PER_CYCLE run the same directed and randomized sequence; each one is
// compared every cycle against a behavioural model built on plain signed
// multiplication and a countdown of NUM_STEPS accumulate cycles.
module tb_mul_seq_ctrl;

  logic clk = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Free-running clock shared by all instances.
  always #5 clk = ~clk;

  function automatic int rows_for(input int idx);
    case (idx)
      0:       return 4;
      1:       return 1;
      2:       return 8;
      default: return 32;
    endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_inst
    localparam int R  = rows_for(gi);
    localparam int NS = 32 / R;

    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a         = '0;
    logic [31:0] b         = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [63:0] p;

    bit          finished  = 1'b0;
    bit          chk_en    = 1'b0;

    bit          m_pending = 1'b0;
    bit          m_ready   = 1'b0;
    int          m_left    = 0;
    logic [63:0] m_prod    = '0;
    logic [63:0] m_p       = '0;

    mul_seq_ctrl #(.ROWS_PER_CYCLE(R)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .p        (p),
      .busy     (busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
        fails++;
        $display("[TB] FAIL R=%0d %s: got %h expected %h", R, name, act, exp);
      end
    endtask

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    // Reference: exact signed product, ready NUM_STEPS edges after acceptance.
    always @(posedge clk) begin
      if (rst) begin
        m_pending <= 1'b0;
        m_ready   <= 1'b0;
        m_p       <= '0;
      end else if (m_ready) begin
        if (out_ready) m_ready <= 1'b0;
      end else if (m_pending) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_pending <= 1'b0;
          m_ready   <= 1'b1;
          m_p       <= m_prod;
        end
      end else if (in_valid) begin
        m_pending <= 1'b1;
        m_left    <= NS;
        m_prod    <= 64'(longint'($signed(a)) * longint'($signed(b)));
      end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
      if (chk_en) begin
        checkOutput("in_ready",  64'(in_ready),  64'(!(m_pending || m_ready)));
        checkOutput("busy",      64'(busy),      64'(m_pending || m_ready));
        checkOutput("out_valid", 64'(out_valid), 64'(m_ready));
        checkOutput("p",         p,              m_p);
      end
    end

    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
        tick();
        n++;
      end
      checkOutput("accept_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      tick();
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
    endtask

    task automatic waitResult(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
        tick();
        lat++;
      end
      checkOutput("result_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic takeResult();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("in_ready_after_take", 64'(in_ready), 64'd1);
    endtask

    task automatic directedOp(input string name, input logic [31:0] av, input logic [31:0] bv,
                              input logic [63:0] exp);
      int lat;
      applyStimulus(av, bv);
      waitResult(lat);
      checkOutput({name, "_latency"}, 64'(lat), 64'(NS));
      checkOutput({name, "_p"}, p, exp);
      takeResult();
    endtask

    function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
        0:       return 32'h0000_0000;
        1:       return 32'h0000_0001;
        2:       return 32'hFFFF_FFFF;
        3:       return 32'h8000_0000;
        4:       return 32'h7FFF_FFFF;
        default: return $urandom;
      endcase
    endfunction

    // Directed sequence followed by randomized traffic with random backpressure.
    initial begin
      int  lat;
      int  n;
      int  seen;
      bit  fired;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_busy",      64'(busy),      64'd0);
      checkOutput("reset_p",         p,              64'd0);

      directedOp("3x5",       32'd3,          32'd5,          64'h0000_0000_0000_000F);
      directedOp("m7x3",      32'hFFFF_FFF9,  32'd3,          64'hFFFF_FFFF_FFFF_FFEB);
      directedOp("m1xm1",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001);
      directedOp("min_x_min", 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
      directedOp("max_x_min", 32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000);

      applyStimulus(32'd1000, 32'hFFFF_FFFD);
      waitResult(lat);
      for (int i = 0; i < 20; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = $urandom;
        b        = $urandom;
        tick();
        checkOutput("bp_p",         p,               64'hFFFF_FFFF_FFFF_F448);
        checkOutput("bp_out_valid", 64'(out_valid),  64'd1);
        checkOutput("bp_in_ready",  64'(in_ready),   64'd0);
      end
      in_valid = 1'b0;
      takeResult();

      applyStimulus(32'd11, 32'd13);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst_mid_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_mid_p",         p,              64'd0);
      checkOutput("rst_mid_in_ready",  64'(in_ready),  64'd1);
      checkOutput("rst_mid_busy",      64'(busy),      64'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (out_valid) seen++;
      end
      checkOutput("rst_no_stale", 64'(seen), 64'd0);
      directedOp("after_rst_2x2", 32'd2, 32'd2, 64'd4);

      for (int i = 0; i < 600; i++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
        applyStimulus(pickOperand(), pickOperand());
        n     = 0;
        fired = 1'b0;
        while (!fired && n < 200) begin
          out_ready = 1'($urandom_range(0, 1));
          in_valid  = 1'($urandom_range(0, 1));
          a         = $urandom;
          b         = $urandom;
          fired     = out_valid && out_ready;
          tick();
          n++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("random_drain", 64'(fired), 64'd1);
      end
      finished = 1'b1;
    end
  end

  // Wait for every instance to finish its sequence, then report.
  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int c = 0; c < 95000 && !all_done; c++) begin
      @(posedge clk);
      all_done = g_inst[0].finished && g_inst[1].finished &&
                 g_inst[2].finished && g_inst[3].finished;
    end
    tests++;
    if (!all_done) begin
      fails++;
      $display("[TB] FAIL global_timeout: got not-finished expected finished");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
